// File: rtl/ffe_pkg.sv
// ffe_pkg: shared definitions for the programmable FFE FIR.
//   coeff_state_t : coefficient load FSM states (IDLE, LOAD, SWAP)
//   clog2         : ceiling log2 used for pointer and accumulator sizing
//   acc_width     : full-precision accumulator width
//   round_shift   : right shift from product format to output format
//   sat_round     : round half up, then clamp (FFE_SAT_EN defined) or wrap
// Build option: FFE_SAT_EN selects output saturation instead of wrap.
package ffe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SWAP = 2'd2
    } coeff_state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int acc_width(input int nb_in, input int nb_coeff, input int fir_len);
        return nb_in + nb_coeff + clog2(fir_len);
    endfunction

    function automatic int round_shift(input int nbf_in, input int nbf_coeff, input int nbf_out);
        return nbf_in + nbf_coeff - nbf_out;
    endfunction

    // Works on a 64-bit sign-extended accumulator so the rounding offset can
    // never overflow. The result is sign-extended from nb_out bits.
    function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                      input int sh,
                                                      input int nb_out);
        logic signed [63:0] r;
        r = acc;
        if (sh > 0) begin
            r = (acc + (64'sd1 <<< (sh - 1))) >>> sh;
        end
`ifdef FFE_SAT_EN
        if (r > ((64'sd1 <<< (nb_out - 1)) - 64'sd1)) begin
            r = (64'sd1 <<< (nb_out - 1)) - 64'sd1;
        end else if (r < -(64'sd1 <<< (nb_out - 1))) begin
            r = -(64'sd1 <<< (nb_out - 1));
        end
`else
        // Keep only the low nb_out bits (two's-complement wrap).
        r = (r <<< (64 - nb_out)) >>> (64 - nb_out);
`endif
        return r;
    endfunction

endpackage

// File: rtl/ffe_coeff_bank.sv
// ffe_coeff_bank: shadow/active coefficient banks with the load FSM.
//   clk_sys     : clock, rising edge
//   reset       : synchronous active-high reset; both banks return to preset
//   coeff_start : begin (or restart) a load, pointer = 0
//   coeff_valid : coeff qualifier, only honoured during a load
//   coeff       : coefficient word, tap 0 first
//   coeff_busy  : high while the FSM is not IDLE
//   coeff_swap  : one-cycle pulse while in SWAP
//   active_flat : active bank, tap k at [k*NB_COEFF +: NB_COEFF]
// Build option: FFE_SAT_EN has no effect here.
//
// state | meaning
// IDLE  | waiting for coeff_start, valid words ignored
// LOAD  | writing shadow[ptr] on each valid word
// SWAP  | one cycle, active bank takes the shadow bank
module ffe_coeff_bank
    import ffe_pkg::*;
#(
    parameter int FIR_LEN    = 21,
    parameter int NB_COEFF   = 8,
    parameter int CENTER_TAP = 10
) (
    input  logic                         clk_sys,
    input  logic                         reset,
    input  logic                         coeff_start,
    input  logic                         coeff_valid,
    input  logic [NB_COEFF-1:0]          coeff,
    output logic                         coeff_busy,
    output logic                         coeff_swap,
    output logic [FIR_LEN*NB_COEFF-1:0]  active_flat
);

    localparam int PW = clog2(FIR_LEN);
    localparam logic [PW-1:0] LAST = PW'(FIR_LEN - 1);
    localparam logic [NB_COEFF-1:0] PRESET = {1'b0, {(NB_COEFF-1){1'b1}}};

    coeff_state_t        state;
    logic [PW-1:0]       ptr;
    logic [NB_COEFF-1:0] shadow [FIR_LEN];
    logic [NB_COEFF-1:0] active [FIR_LEN];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            coeff_busy <= 1'b0;
            coeff_swap <= 1'b0;
            for (int k = 0; k < FIR_LEN; k++) begin
                shadow[k] <= (k == CENTER_TAP) ? PRESET : '0;
                active[k] <= (k == CENTER_TAP) ? PRESET : '0;
            end
        end else begin
            coeff_swap <= 1'b0;
            case (state)
                IDLE, LOAD: begin
                    if (coeff_start) begin
                        // Restart wins over a simultaneous word, which lands in tap 0.
                        state      <= LOAD;
                        coeff_busy <= 1'b1;
                        if (coeff_valid) begin
                            shadow[0] <= coeff;
                            ptr       <= PW'(1);
                        end else begin
                            ptr <= '0;
                        end
                    end else if (state == LOAD && coeff_valid) begin
                        shadow[ptr] <= coeff;
                        if (ptr == LAST) begin
                            state      <= SWAP;
                            coeff_swap <= 1'b1;
                            ptr        <= '0;
                        end else begin
                            ptr <= ptr + PW'(1);
                        end
                    end
                end
                SWAP: begin
                    for (int k = 0; k < FIR_LEN; k++) begin
                        active[k] <= shadow[k];
                    end
                    state      <= IDLE;
                    coeff_busy <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    coeff_busy <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < FIR_LEN; k++) begin : g_flat
        assign active_flat[k*NB_COEFF +: NB_COEFF] = active[k];
    end

endmodule

// File: rtl/ffe_fir_prog.sv
// ffe_fir_prog: programmable-coefficient FFE FIR with stall and 3-stage pipeline.
//   i_clock, i_reset               : clock / synchronous active-high reset
//   i_en                           : data path clock enable (low = hold)
//   i_valid, i_sample              : input sample S(NB_IN,NBF_IN) and qualifier
//   o_sample, o_valid              : output S(NB_OUT,NBF_OUT) and qualifier
//   i_coeff_start, i_coeff_valid,
//   i_coeff                        : coefficient load interface, tap 0 first
//   o_coeff_busy, o_coeff_swap     : load in progress / bank swap pulse
// Build option: FFE_SAT_EN clamps the output instead of wrapping.
// NBF_OUT must not exceed NBF_IN+NBF_COEFF.
module ffe_fir_prog
    import ffe_pkg::*;
#(
    parameter int FIR_LEN    = 21,
    parameter int NB_COEFF   = 8,
    parameter int NBF_COEFF  = 7,
    parameter int NB_IN      = 8,
    parameter int NBF_IN     = 7,
    parameter int NB_OUT     = 12,
    parameter int NBF_OUT    = 10,
    parameter int CENTER_TAP = 10
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_en,
    input  logic                i_valid,
    input  logic [NB_IN-1:0]    i_sample,
    output logic [NB_OUT-1:0]   o_sample,
    output logic                o_valid,
    input  logic                i_coeff_start,
    input  logic                i_coeff_valid,
    input  logic [NB_COEFF-1:0] i_coeff,
    output logic                o_coeff_busy,
    output logic                o_coeff_swap
);

    localparam int NB_PROD = NB_IN + NB_COEFF;
    localparam int NB_ACC  = acc_width(NB_IN, NB_COEFF, FIR_LEN);
    localparam int SH      = round_shift(NBF_IN, NBF_COEFF, NBF_OUT);

    logic [FIR_LEN*NB_COEFF-1:0] coeff_flat;
    logic signed [NB_IN-1:0]     taps  [FIR_LEN];
    logic signed [NB_PROD-1:0]   prods [FIR_LEN];
    logic signed [NB_ACC-1:0]    sum_d;
    logic signed [NB_ACC-1:0]    sum_q;
    logic                        valid_tap;
    logic                        valid_s1;
    logic                        valid_s2;

    ffe_coeff_bank #(
        .FIR_LEN    (FIR_LEN),
        .NB_COEFF   (NB_COEFF),
        .CENTER_TAP (CENTER_TAP)
    ) u_bank (
        .clk_sys     (i_clock),
        .reset       (i_reset),
        .coeff_start (i_coeff_start),
        .coeff_valid (i_coeff_valid),
        .coeff       (i_coeff),
        .coeff_busy  (o_coeff_busy),
        .coeff_swap  (o_coeff_swap),
        .active_flat (coeff_flat)
    );

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < FIR_LEN; k++) begin
            sum_d = sum_d + NB_ACC'(prods[k]);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int k = 0; k < FIR_LEN; k++) begin
                taps[k]  <= '0;
                prods[k] <= '0;
            end
            sum_q     <= '0;
            o_sample  <= '0;
            valid_tap <= 1'b0;
            valid_s1  <= 1'b0;
            valid_s2  <= 1'b0;
            o_valid   <= 1'b0;
        end else if (i_en) begin
            // Zero-fill when no sample is offered so the line keeps moving.
            taps[0] <= i_valid ? $signed(i_sample) : '0;
            for (int k = 1; k < FIR_LEN; k++) begin
                taps[k] <= taps[k-1];
            end
            for (int k = 0; k < FIR_LEN; k++) begin
                prods[k] <= NB_PROD'(taps[k]) *
                            NB_PROD'($signed(coeff_flat[k*NB_COEFF +: NB_COEFF]));
            end
            sum_q     <= sum_d;
            o_sample  <= NB_OUT'(sat_round(64'(sum_q), SH, NB_OUT));
            valid_tap <= i_valid;
            valid_s1  <= valid_tap;
            valid_s2  <= valid_s1;
            o_valid   <= valid_s2;
        end
    end

endmodule
